// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator: sums a programmable number of tree-adder beats, in one 32-bit lane
// or two independent 16-bit lanes, and then presents the total on a valid/ready output.
module tree_sum_accumulator #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] acc_len,
    input  logic             halvedPrecision,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    generate
        if (ACC_W != 32) begin : g_bad_acc_w
            $fatal(1, "tree_sum_accumulator: ACC_W must be 32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             mode_q, mode_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0] eff_len, cnt_inc;
    logic             beat;

    // Halved mode splits the add so lane0 can never carry into lane1.
    function automatic logic [ACC_W-1:0] lane_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                                  input logic halved);
        return halved ? {a[ACC_W-1:ACC_W/2] + b[ACC_W-1:ACC_W/2], a[ACC_W/2-1:0] + b[ACC_W/2-1:0]}
                      : a + b;
    endfunction

    assign in_ready  = (state_q != DRAIN);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_valid = out_valid_q;
    assign beat      = in_valid && in_ready;
    assign eff_len   = (acc_len == '0) ? CNT_W'(1) : acc_len;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (beat) begin
                len_d       = eff_len;
                mode_d      = halvedPrecision;
                acc_d       = in_sum;
                cnt_d       = CNT_W'(1);
                state_d     = (eff_len == CNT_W'(1)) ? DRAIN : ACCUM;
                out_valid_d = (eff_len == CNT_W'(1));
            end
            ACCUM: if (beat) begin
                acc_d       = lane_add(acc_q, in_sum, mode_q);
                cnt_d       = cnt_inc;
                state_d     = (cnt_inc == len_q) ? DRAIN : ACCUM;
                out_valid_d = (cnt_inc == len_q);
            end
            DRAIN: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
